// File: rtl/stream_mux2to1_rr.sv
// stream_mux2to1_rr: merges two valid/ready streams with burst-limited round-robin arbitration.
// One registered output stage; s carries the source channel of each beat on y.
module stream_mux2to1_rr #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d0,
   input  logic              v0,
   output logic              r0,
   input  logic [DATA_W-1:0] d1,
   input  logic              v1,
   output logic              r1,
   output logic [DATA_W-1:0] y,
   output logic              s,
   output logic              yv,
   input  logic              yr
);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        st;
   logic [CW-1:0] cnt;
   logic          en, lim, grant, xfer;

   // rst_n gates only the readies; the flops see it through their async reset
   assign en    = !yv | yr;
   assign lim   = cnt >= CW'(MAX_BURST);
   assign grant = (v0 & v1) ? (st == OWN0 ? lim : st == OWN1 ? !lim : 1'b0) : (v1 & !v0);
   assign r0    = rst_n & en & !grant;
   assign r1    = rst_n & en & grant;
   assign xfer  = grant ? v1 : v0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         y   <= '0;
         s   <= 1'b0;
         yv  <= 1'b0;
         st  <= IDLE;
         cnt <= '0;
      end else if (en) begin
         if (xfer) begin
            y  <= grant ? d1 : d0;
            s  <= grant;
            yv <= 1'b1;
            if (st == (grant ? OWN1 : OWN0))
               cnt <= lim ? cnt : cnt + 1'b1;
            else begin
               st  <= grant ? OWN1 : OWN0;
               cnt <= CW'(1);
            end
         end else begin
            yv  <= 1'b0;
            st  <= IDLE;
            cnt <= '0;
         end
      end
endmodule

// File: tb/tb_stream_mux2to1_rr.sv
// tb_stream_mux2to1_rr: random and directed stimulus against an arbitration model and per-channel scoreboard.
module tb_stream_mux2to1_rr;
   localparam int MB = 4;

   logic       clk = 0, rst_n = 0;
   logic [7:0] d0 = 0, d1 = 0, y;
   logic       v0 = 0, v1 = 0, r0, r1, s, yv, yr = 0;

   int n_cmp = 0, n_bad = 0;
   logic [7:0] m_y = 0, seq0 = 0, seq1 = 8'h80, hold_y;
   logic       m_s = 0, m_yv = 0, acc0 = 0, acc1 = 0;
   int         own = -1, run = 0;
   logic [7:0] q0[$], q1[$];

   stream_mux2to1_rr #(.DATA_W(8), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .d0(d0), .v0(v0), .r0(r0), .d1(d1), .v1(v1), .r1(r1),
      .y(y), .s(s), .yv(yv), .yr(yr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // one cycle: inputs already driven after a falling edge
   task automatic step();
      logic       ld, g, x0, x1;
      logic [7:0] e;
      #1;
      ld = rst_n & (!m_yv | yr);
      if (v0 && v1) g = (own < 0) ? 1'b0 : (run < MB ? own[0] : !own[0]);
      else g = v1 && !v0;
      chk("r0", r0, ld & !g);
      chk("r1", r1, ld & g);
      x0 = ld & !g & v0;
      x1 = ld & g & v1;
      acc0 = r0 & v0;
      acc1 = r1 & v1;
      if (acc0) q0.push_back(d0);
      if (acc1) q1.push_back(d1);
      if (yv && yr) begin
         if ((s ? q1.size() : q0.size()) == 0) chk("sb_empty", 1, 0);
         else begin
            e = s ? q1.pop_front() : q0.pop_front();
            chk("sb_order", y, e);
         end
      end
      @(posedge clk);
      if (ld) begin
         if (x0 || x1) begin
            m_y  = x1 ? d1 : d0;
            m_s  = x1;
            m_yv = 1;
            if (own == int'(x1)) run = (run < MB) ? run + 1 : MB;
            else begin
               own = int'(x1);
               run = 1;
            end
         end else begin
            m_yv = 0;
            own  = -1;
            run  = 0;
         end
      end
      if (acc0) seq0++;
      if (acc1) seq1++;
      #1;
      chk("yv", yv, m_yv);
      chk("y", y, m_y);
      chk("s", s, m_s);
      @(negedge clk);
   endtask

   task automatic set(input logic a0, input logic a1, input logic ready);
      v0 = a0;
      v1 = a1;
      d0 = seq0;
      d1 = seq1;
      yr = ready;
   endtask

   task automatic model_reset();
      m_y = 0; m_s = 0; m_yv = 0; own = -1; run = 0;
      q0.delete();
      q1.delete();
   endtask

   initial begin
      // reset with both channels requesting
      set(1, 1, 1);
      @(negedge clk);
      #1;
      chk("rst_yv", yv, 0);
      chk("rst_y", y, 0);
      chk("rst_s", s, 0);
      chk("rst_r0", r0, 0);
      chk("rst_r1", r1, 0);
      @(negedge clk);
      rst_n = 1;
      step();
      chk("first_tie_s", s, 0);
      set(0, 0, 1);
      step();

      // lone channel 1
      seq1 = 8'h5A;
      set(0, 1, 1);
      step();
      chk("single_y", y, 8'h5A);
      chk("single_s", s, 1);
      set(0, 0, 1);
      step();
      chk("single_drop", yv, 0);

      // contention from IDLE: bursts of MB alternate
      for (int k = 0; k < 16; k++) begin
         set(1, 1, 1);
         step();
         chk("cont_s", s, (k / MB) % 2);
      end

      // backpressure keeps the output stable
      hold_y = y;
      for (int k = 0; k < 3; k++) begin
         set(1, 1, 0);
         step();
         chk("bp_y", y, hold_y);
         chk("bp_rdy", r0 | r1, 0);
      end
      set(1, 1, 1);
      step();
      set(0, 0, 1);
      step();

      // early release: channel 0 owns with two beats, then drops
      set(1, 0, 1);
      step();
      step();
      set(0, 1, 1);
      step();
      chk("early_s", s, 1);
      set(0, 0, 1);
      step();
      set(1, 1, 1);
      step();
      chk("idle_tie", s, 0);

      // async reset between edges mid-burst
      step();
      #2;
      rst_n = 0;
      #1;
      chk("arst_yv", yv, 0);
      chk("arst_y", y, 0);
      chk("arst_rdy", r0 | r1, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 6; k++) begin
         set(1, 1, 1);
         step();
         chk("post_rst_s", s, (k / MB) % 2);
      end

      // random traffic with the hold rule respected
      for (int k = 0; k < 600; k++) begin
         if (!v0 || acc0) v0 = $urandom_range(0, 1);
         if (!v1 || acc1) v1 = $urandom_range(0, 1);
         d0 = seq0;
         d1 = seq1;
         yr = $urandom_range(0, 3) != 0;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
